// File: rtl/change_dispenser.sv
// Vend-then-change dispenser: drives the vend motor, then ejects change greedily as Q/D/N coins.
// Optional ACK_TIMEOUT_EN adds a vend/eject acknowledge watchdog that raises the sticky fault flag.
module change_dispenser #(
  parameter int CHANGE_W       = 3,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                release_soda,
  input  logic [CHANGE_W-1:0] change,
  output logic                vend_motor,
  input  logic                vend_done,
  output logic [2:0]          coin_eject,
  input  logic                eject_ack,
  output logic                busy,
  output logic                overrun,
  output logic                fault,
  input  logic                clear_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VEND  = 3'd1,
    S_SEL   = 3'd2,
    S_EJECT = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [CHANGE_W-1:0] r_q;
  logic [CHANGE_W-1:0] r_d;
  logic [CHANGE_W-1:0] r_n;
  logic [CHANGE_W-1:0] r_pq;
  logic [CHANGE_W-1:0] r_pd;
  logic [CHANGE_W-1:0] r_pn;
  logic                r_pend_vld;
  logic [2:0]          r_sel;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_overrun;

  logic [31:0]         w_chg32;
  logic [2:0]          w_rem;
  logic [CHANGE_W-1:0] w_cap_q;
  logic [CHANGE_W-1:0] w_cap_d;
  logic [CHANGE_W-1:0] w_cap_n;
  logic [CHANGE_W-1:0] w_ld_q;
  logic [CHANGE_W-1:0] w_ld_d;
  logic [CHANGE_W-1:0] w_ld_n;

  logic                w_load_work;
  logic                w_store_pend;
  logic                w_pend_clr;
  logic                w_ovr_set;
  logic                w_dec;
  logic                w_timeout;
  logic                w_to_hit;
  logic [2:0]          w_sel_nx;

  // Greedy breakdown in nickels: 5 nickels per quarter, 2 per dime, remainder is a nickel.
  assign w_chg32 = 32'(change);
  assign w_cap_q = CHANGE_W'(w_chg32 / 32'd5);
  assign w_rem   = 3'(w_chg32 % 32'd5);
  assign w_cap_d = CHANGE_W'(w_rem[2:1]);
  assign w_cap_n = CHANGE_W'(w_rem[0]);

  assign w_ld_q = r_pend_vld ? r_pq : w_cap_q;
  assign w_ld_d = r_pend_vld ? r_pd : w_cap_d;
  assign w_ld_n = r_pend_vld ? r_pn : w_cap_n;

`ifdef ACK_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_fault;

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts whenever VEND/EJECT is (re)entered, so each wait gets a full budget.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (((r_state == S_VEND) || (r_state == S_EJECT)) && (w_state_nx == r_state)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_timeout | (r_fault & ~clear_err);
    end
  end

  assign fault = r_fault;
`else
  logic w_unused_to;

  assign w_unused_to = (TIMEOUT_CYCLES == 0);
  assign w_to_hit    = 1'b0;
  assign fault       = 1'b0;
`endif

  always_comb begin
    w_state_nx   = r_state;
    w_load_work  = 1'b0;
    w_store_pend = 1'b0;
    w_pend_clr   = 1'b0;
    w_ovr_set    = 1'b0;
    w_dec        = 1'b0;
    w_timeout    = 1'b0;
    w_sel_nx     = r_sel;

    case (r_state)
      S_IDLE: begin
        // Pending request has priority; a simultaneous new request refills the freed slot.
        if (r_pend_vld) begin
          w_state_nx  = S_VEND;
          w_load_work = 1'b1;
          if (release_soda) begin
            w_store_pend = 1'b1;
          end else begin
            w_pend_clr = 1'b1;
          end
        end else if (release_soda) begin
          w_state_nx  = S_VEND;
          w_load_work = 1'b1;
        end
      end
      S_VEND: begin
        if (vend_done) begin
          w_state_nx = S_SEL;
        end else if (w_to_hit) begin
          w_timeout  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_SEL: begin
        if (r_q != '0) begin
          w_sel_nx   = 3'b001;
          w_state_nx = S_EJECT;
        end else if (r_d != '0) begin
          w_sel_nx   = 3'b010;
          w_state_nx = S_EJECT;
        end else if (r_n != '0) begin
          w_sel_nx   = 3'b100;
          w_state_nx = S_EJECT;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_EJECT: begin
        if (eject_ack) begin
          w_dec      = 1'b1;
          w_state_nx = (GAP_CYCLES == 0) ? S_SEL : S_GAP;
        end else if (w_to_hit) begin
          w_timeout  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          w_state_nx = S_SEL;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if ((r_state != S_IDLE) && release_soda) begin
      if (!r_pend_vld) begin
        w_store_pend = 1'b1;
      end else begin
        w_ovr_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
      r_d <= '0;
      r_n <= '0;
    end else if (w_load_work) begin
      r_q <= w_ld_q;
      r_d <= w_ld_d;
      r_n <= w_ld_n;
    end else if (w_dec) begin
      if (r_sel[0]) r_q <= r_q - 1'b1;
      if (r_sel[1]) r_d <= r_d - 1'b1;
      if (r_sel[2]) r_n <= r_n - 1'b1;
    end else if (w_timeout) begin
      r_q <= '0;
      r_d <= '0;
      r_n <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pq       <= '0;
      r_pd       <= '0;
      r_pn       <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_store_pend) begin
      r_pq       <= w_cap_q;
      r_pd       <= w_cap_d;
      r_pn       <= w_cap_n;
      r_pend_vld <= 1'b1;
    end else if (w_pend_clr) begin
      r_pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sel     <= 3'b000;
      r_gap_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_sel     <= w_sel_nx;
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      // A drop in the same cycle as clear_err must survive the clear.
      r_overrun <= w_ovr_set | (r_overrun & ~clear_err);
    end
  end

  assign vend_motor = (r_state == S_VEND);
  assign coin_eject = (r_state == S_EJECT) ? r_sel : 3'b000;
  assign busy       = (r_state != S_IDLE) | r_pend_vld;
  assign overrun    = r_overrun;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream consumer of the vending FSM's `release_soda` / `change` outputs.
- Drives the soda vend motor, then ejects change as physical coins using a greedy quarter/dime/nickel breakdown.
- Coin ejector uses the same one-hot coin encoding as the coin sensor: bit0 quarter, bit1 dime, bit2 nickel.
- Holds one pending request so back-to-back sales are not lost; reports overrun and (optionally) ejector timeout.

Parameters:
- CHANGE_W, 3: width of `change` input; value is change owed in nickels (0..2^CHANGE_W-1).
- GAP_CYCLES, 2: idle cycles with `coin_eject`=0 between consecutive coin ejections; 0 allowed.
- TIMEOUT_CYCLES, 1024: cycles to wait for `vend_done`/`eject_ack` before fault (used only with ACK_TIMEOUT_EN).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- release_soda  in  1  sale strobe from vending FSM; one request per high cycle.
- change  in  CHANGE_W  change owed in nickels; sampled only when `release_soda`=1.
- vend_motor  out  1  held high until `vend_done`.
- vend_done  in  1  vend mechanism complete.
- coin_eject  out  3  one-hot coin select (001 Q, 010 D, 100 N); held until `eject_ack`.
- eject_ack  in  1  ejector accepted current coin.
- busy  out  1  = (state != IDLE) or pending valid.
- overrun  out  1  sticky: request dropped because the pending slot was full.
- fault  out  1  sticky timeout flag; constant 0 without ACK_TIMEOUT_EN.
- clear_err  in  1  synchronous clear of `overrun` and `fault`.

Behaviour:
- Reset (reset=0, async): state IDLE, pending cleared, counters 0. All outputs 0: `vend_motor`, `coin_eject`, `busy`, `overrun`, `fault`.
- Capture: on `release_soda`=1, compute q=change/5, r=change%5, d=r/2, n=r%2. Registers are wide enough for the max CHANGE_W value.
- Capture destination:
  - IDLE with pending empty: load into working regs; next cycle is VEND.
  - Otherwise, pending empty: store to pending.
  - Otherwise, pending full: drop the request and set `overrun`.
- IDLE with pending valid: load pending into working regs and go to VEND. A simultaneous new request goes into the freed pending slot.
- VEND: `vend_motor`=1. Latency: `release_soda` high at cycle 0 gives `vend_motor` high at cycle 1. On `vend_done`=1, go to SEL; `vend_motor` is 0 from the next cycle.
- SEL (one cycle, all outputs 0):
  - q>0 selects quarter.
  - Else d>0 selects dime.
  - Else n>0 selects nickel.
  - Else go to IDLE.
- EJECT: `coin_eject` = selected one-hot, held stable until `eject_ack`=1. On ack, decrement the selected count and go to GAP (or to SEL if GAP_CYCLES=0). `coin_eject` is 0 from the next cycle.
- GAP: GAP_CYCLES cycles with `coin_eject`=0, then SEL.
- `change`=0: VEND, then SEL, then IDLE; no coin ejected.
- Ignored inputs:
  - `eject_ack` outside EJECT.
  - `vend_done` outside VEND.
  - `change` when `release_soda`=0.
- `coin_eject` is never multi-hot; `vend_motor` and `coin_eject` are never high together.
- Sticky flags: `clear_err` clears both flags. If a set event and `clear_err` occur in the same cycle, the flag stays set.

Optional Feature:
- Macro: ACK_TIMEOUT_EN.
- Defined: a counter runs in VEND and EJECT and resets on state entry. If it reaches TIMEOUT_CYCLES without `vend_done`/`eject_ack`:
  - set `fault`;
  - drop outputs;
  - clear remaining working counts;
  - go to IDLE, where pending is served normally.
- Not defined: VEND and EJECT wait indefinitely; no counter logic is synthesized; `fault` is tied 0.

Test Plan:
- `release_soda`=1, `change`=0 → `vend_motor`=1 at cycle 1 until `vend_done`; `coin_eject` stays 000; `busy`=0 after return to IDLE.
- `change`=3 (15c), GAP_CYCLES=2 → vend; `coin_eject`=010 until ack; 2 cycles of 000; `coin_eject`=100 until ack; IDLE.
- `change`=7 (35c) → vend, then 001 (quarter), gap, then 010 (dime); no nickel ejected.
- Requests A, B, C each 1 cycle apart while A is vending → B pending, C dropped with `overrun`=1; B served after A; `clear_err` → `overrun`=0.
- Assert reset during EJECT with a pending request → `coin_eject`=000 and `busy`=0 immediately; after release, state is IDLE and pending is empty.
- With ACK_TIMEOUT_EN, TIMEOUT_CYCLES=8, `eject_ack` held 0 → `fault`=1 after 8 EJECT cycles; `coin_eject`=000; IDLE.
